// File: rtl/bram_stream_reader_pkg.sv
// Shared types for the BRAM stream reader: FSM state encoding and read-buffer depth.
package bram_stream_reader_pkg;
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
    localparam int FIFO_DEPTH = 2;
endpackage

// File: rtl/bram_stream_reader_fifo.sv
// Two-entry synchronous FIFO that holds BRAM words (data plus last flag) until the consumer accepts them.
module bram_stream_reader_fifo
    import bram_stream_reader_pkg::*;
#(
    parameter int WIDTH = 33
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       count
);
    logic [FIFO_DEPTH-1:0][WIDTH-1:0] mem;
    logic                             wr_ptr;
    logic                             rd_ptr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];
endmodule

// File: rtl/bram_stream_reader.sv
// Walks a BRAM address window and re-emits the words as a valid/ready stream with a last marker.
// Optional BRAM_STREAM_READER_REPEAT_EN streams the window repeat_count times per command.
module bram_stream_reader
    import bram_stream_reader_pkg::*;
#(
    parameter int RAM_WIDTH     = 32,
    parameter int RAM_ADDR_BITS = 9
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [RAM_ADDR_BITS-1:0] base_address,
    input  logic [RAM_ADDR_BITS:0]   length,
`ifdef BRAM_STREAM_READER_REPEAT_EN
    input  logic [7:0]               repeat_count,
`endif
    output logic                     busy,
    output logic                     done,
    output logic                     ram_enable,
    output logic                     write_enable,
    output logic [RAM_ADDR_BITS-1:0] address,
    input  logic [RAM_WIDTH-1:0]     ram_data,
    output logic [RAM_WIDTH-1:0]     out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last
);
    localparam int CW = RAM_ADDR_BITS + 1;

    state_t                   state, state_nxt;
    logic [RAM_ADDR_BITS-1:0] base_q;
    logic [CW-1:0]            len_q;
    logic [CW-1:0]            issued_q;
    logic                     inflight_q;
    logic                     last_q;
    logic [1:0]               fifo_count;
    logic [RAM_WIDTH:0]       head;
    logic                     pop;
    logic                     issue;
    logic                     word_last;
    logic                     pass_last;

`ifdef BRAM_STREAM_READER_REPEAT_EN
    logic [7:0] reps_q;
    logic [7:0] pass_q;
    assign pass_last = (pass_q == reps_q - 8'd1);
`else
    assign pass_last = 1'b1;
`endif

    assign pop       = out_valid && out_ready;
    assign word_last = (issued_q == len_q - CW'(1));
    // Buffer space must cover everything already stored or still coming back from the BRAM.
    assign issue     = (state == READ) &&
                       ((3'(fifo_count) + 3'(inflight_q)) < (3'd2 + 3'(pop)));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = (length == '0) ? DONE : READ;
            READ:  if (issue && word_last && pass_last) state_nxt = DRAIN;
            DRAIN: if (!inflight_q && (fifo_count == {1'b0, pop})) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            base_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            inflight_q <= 1'b0;
            last_q     <= 1'b0;
`ifdef BRAM_STREAM_READER_REPEAT_EN
            reps_q     <= 8'd0;
            pass_q     <= 8'd0;
`endif
        end else begin
            inflight_q <= issue;
            last_q     <= issue && word_last && pass_last;
            if (state == IDLE && start) begin
                base_q   <= base_address;
                len_q    <= length;
                issued_q <= '0;
`ifdef BRAM_STREAM_READER_REPEAT_EN
                reps_q   <= (repeat_count == 8'd0) ? 8'd1 : repeat_count;
                pass_q   <= 8'd0;
`endif
            end else if (issue) begin
                // Rewinding at the end of a pass also restarts the next pass at base.
                if (word_last) begin
                    issued_q <= '0;
`ifdef BRAM_STREAM_READER_REPEAT_EN
                    pass_q   <= pass_q + 8'd1;
`endif
                end else begin
                    issued_q <= issued_q + CW'(1);
                end
            end
        end
    end

    bram_stream_reader_fifo #(.WIDTH(RAM_WIDTH + 1)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (inflight_q),
        .push_data ({last_q, ram_data}),
        .pop       (pop),
        .head_data (head),
        .count     (fifo_count)
    );

    assign busy         = (state != IDLE);
    assign done         = (state == DONE);
    assign ram_enable   = issue;
    assign write_enable = 1'b0;
    assign address      = base_q + issued_q[RAM_ADDR_BITS-1:0];
    assign out_valid    = (fifo_count != 2'd0);
    assign out_data     = head[RAM_WIDTH-1:0];
    assign out_last     = head[RAM_WIDTH];
endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a behavioural one-cycle-latency BRAM.
module tb_bram_stream_reader;
    localparam int AW = 9;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_address;
    logic [AW:0]   length;
    logic          busy, done, ram_enable, write_enable;
    logic [AW-1:0] address;
    logic [DW-1:0] ram_data;
    logic [DW-1:0] out_data;
    logic          out_valid, out_ready, out_last;
`ifdef BRAM_STREAM_READER_REPEAT_EN
    logic [7:0]    repeat_count;
`endif

    int checks   = 0;
    int failures = 0;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    always #5 clock = ~clock;

    always @(posedge clock)
        if (ram_enable) ram_data <= mem[address];

    bram_stream_reader dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .base_address (base_address),
        .length       (length),
`ifdef BRAM_STREAM_READER_REPEAT_EN
        .repeat_count (repeat_count),
`endif
        .busy         (busy),
        .done         (done),
        .ram_enable   (ram_enable),
        .write_enable (write_enable),
        .address      (address),
        .ram_data     (ram_data),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  busy,       0);
        chk({tag, "_done"},  done,       0);
        chk({tag, "_en"},    ram_enable, 0);
        chk({tag, "_we"},    write_enable, 0);
        chk({tag, "_addr"},  address,    0);
        chk({tag, "_vld"},   out_valid,  0);
        chk({tag, "_data"},  out_data,   0);
        chk({tag, "_last"},  out_last,   0);
    endtask

    // Runs one command, checking every issued address, every accepted word, the
    // outstanding-read bound and the completion handshake.
    task automatic run_cmd(input string tag, input logic [AW-1:0] base, input int len,
                           input int reps, input bit rnd, input bit timing);
        int issued = 0, popped = 0, done_cyc = -1, first_vld = -1, total;
        total        = len * reps;
        base_address = base;
        length       = (AW+1)'(len);
`ifdef BRAM_STREAM_READER_REPEAT_EN
        repeat_count = 8'(reps);
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 2000 && done_cyc < 0; c++) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (ram_enable) begin
                chk({tag, "_addr"}, address, (int'(base) + issued % len) % (1 << AW));
                issued++;
            end
            if (out_valid && first_vld < 0) first_vld = c;
            if (out_valid && out_ready) begin
                chk({tag, "_data"}, out_data, mem[(int'(base) + popped % len) % (1 << AW)]);
                chk({tag, "_last"}, out_last, popped == total - 1);
                popped++;
            end
            chk({tag, "_outstanding"}, (issued - popped) <= 2, 1);
            if (done) done_cyc = c;
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk({tag, "_done_seen"}, done_cyc >= 0, 1);
        chk({tag, "_words"},     popped, total);
        chk({tag, "_reads"},     issued, total);
        chk({tag, "_post_busy"}, busy, 0);
        chk({tag, "_post_done"}, done, 0);
        chk({tag, "_post_vld"},  out_valid, 0);
        if (timing) begin
            chk({tag, "_done_cyc"},  done_cyc, total + 3);
            chk({tag, "_first_vld"}, first_vld, 3);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hC0DE_0000 | i;
        reset = 1'b1; start = 1'b0; base_address = '0; length = '0; out_ready = 1'b1;
`ifdef BRAM_STREAM_READER_REPEAT_EN
        repeat_count = 8'd0;
`endif
        repeat (3) @(posedge clock);
        #1;
        chk_all_zero("reset");
        reset = 1'b0;
        tick();

        // Cycle-exact walk of a 4-word window from 0x010.
        base_address = 9'h010; length = 10'd4; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            #1;
            chk($sformatf("t1_en_c%0d", c), ram_enable, (c >= 1 && c <= 4));
            if (c >= 1 && c <= 4) chk($sformatf("t1_addr_c%0d", c), address, 9'h010 + c - 1);
            chk($sformatf("t1_vld_c%0d", c), out_valid, (c >= 3 && c <= 6));
            if (c >= 3 && c <= 6) begin
                chk($sformatf("t1_data_c%0d", c), out_data, mem[16 + c - 3]);
                chk($sformatf("t1_last_c%0d", c), out_last, c == 6);
            end
            chk($sformatf("t1_done_c%0d", c), done, c == 7);
            chk($sformatf("t1_busy_c%0d", c), busy, c <= 7);
            tick();
        end

        run_cmd("wrap", 9'h1FE, 4, 1, 1'b0, 1'b1);
        run_cmd("rnd", 9'h100, 8, 1, 1'b1, 1'b0);
        run_cmd("len1", 9'h033, 1, 1, 1'b0, 1'b1);
        run_cmd("full", 9'h005, 512, 1, 1'b0, 1'b1);

        // Zero-length command completes without touching the BRAM.
        base_address = 9'h000; length = 10'd0; start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        chk("zero_done_c1", done, 1);
        chk("zero_busy_c1", busy, 1);
        chk("zero_en_c1", ram_enable, 0);
        chk("zero_vld_c1", out_valid, 0);
        tick();
        chk("zero_done_c2", done, 0);
        chk("zero_busy_c2", busy, 0);
        chk("zero_en_c2", ram_enable, 0);
        chk("zero_vld_c2", out_valid, 0);

        // Reset in cycle 4 of a 16-word command.
        base_address = 9'h040; length = 10'd16; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("rst_mid_en", ram_enable, 1);
        chk("rst_mid_vld", out_valid, 1);
        reset = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_hold_done", done, 0);
        end
        reset = 1'b0;
        tick();
        chk("rst_idle_done", done, 0);
        chk("rst_idle_vld", out_valid, 0);
        run_cmd("after_rst", 9'h080, 3, 1, 1'b0, 1'b1);

`ifdef BRAM_STREAM_READER_REPEAT_EN
        run_cmd("rep3", 9'h020, 2, 3, 1'b0, 1'b1);
        run_cmd("rep_rnd", 9'h1FF, 3, 2, 1'b1, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bram_stream_reader.md
# bram_stream_reader

Read-side controller for the single-port synchronous BRAM used by the first-convolution datapath. On a start command it walks a window of BRAM addresses, drives the BRAM enable/address pins, absorbs the BRAM's one-cycle read latency and re-emits the words as a valid/ready stream with a last marker. It sits between a weight/feature BRAM and the convolution MAC array, and it lets the array apply backpressure without losing words.

## Interface
- RAM_WIDTH, 32: BRAM word width and stream data width.
- RAM_ADDR_BITS, 9: BRAM address width; BRAM depth is 2**RAM_ADDR_BITS.
- clock  in  1  sole clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- base_address  in  RAM_ADDR_BITS  first address of the window; captured on an accepted start.
- length  in  RAM_ADDR_BITS+1  number of words in the window, 0..2**RAM_ADDR_BITS; captured on an accepted start.
- busy  out  1  high from the cycle after an accepted start until the cycle done is high, inclusive.
- done  out  1  one-cycle pulse when the command completes.
- ram_enable  out  1  BRAM enable; high only on cycles that issue a read.
- write_enable  out  1  tied to 0.
- address  out  RAM_ADDR_BITS  BRAM read address.
- ram_data  in  RAM_WIDTH  BRAM output_data; valid the cycle after a read is issued.
- out_data  out  RAM_WIDTH  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready from the consumer.
- out_last  out  1  marks the final word of the command; qualified by out_valid.

## Operation
- FSM states:
  - IDLE: start=1 with length>0 goes to READ; start=1 with length=0 goes to DONE; otherwise stays in IDLE.
  - READ: issues reads; after the read of word length-1 is issued, goes to DRAIN.
  - DRAIN: goes to DONE when there is no read in flight and the FIFO is empty.
  - DONE: asserts done for one cycle, then goes to IDLE.
- start is ignored outside IDLE. busy=0 only in IDLE.
- Address generation:
  - Address k = (base_address + k) mod 2**RAM_ADDR_BITS. Wrap-around is legal and silent.
  - The issued-word counter has width RAM_ADDR_BITS+1, so length = 2**RAM_ADDR_BITS reads every word exactly once.
- Read buffering:
  - A 2-entry FIFO holds the read data.
  - A read is issued in a cycle only if occupancy + inflight − pop < 2, where:
    - inflight is 1 if a read was issued the previous cycle;
    - pop is out_valid && out_ready.
  - This rule guarantees no overflow.
- Stream rules:
  - out_data, out_valid and out_last are driven from the FIFO head.
  - Once out_valid is high, out_data and out_last hold until a handshake.
  - out_last=1 only on word length-1.
- Reset values: every output is 0, state is IDLE, the FIFO is empty and the counters are 0.
- Reset mid-command: the command is abandoned, no done pulse is produced, and buffered words are discarded.

## Timing
- Example with start accepted at cycle 0:
  - state=READ, busy=1, and the first ram_enable/address=base_address all occur in cycle 1;
  - ram_data is valid in cycle 2 and written to the FIFO at the end of cycle 2;
  - first out_valid=1 is in cycle 3.
- With out_ready held high, throughput is 1 word/cycle; the last word handshakes in cycle length+2.
- done is high in cycle length+3 (DRAIN→DONE is taken on the cycle after the last pop). busy falls in cycle length+4 (IDLE).
- length=0: done in cycle 1, with no ram_enable and no out_valid.
- With out_ready low, the reader issues at most 2 reads beyond the last pop, then stalls with ram_enable=0.

## Configuration
- BRAM_STREAM_READER_REPEAT_EN defined:
  - Adds the input repeat (8 bits), captured on start. repeat=0 is treated as 1.
  - The window is streamed repeat times back-to-back with no gap, and the address restarts at base_address for each pass.
  - out_last is asserted only on the final word of the final pass. done occurs once, after the final pass.
- BRAM_STREAM_READER_REPEAT_EN undefined: the repeat port is absent, exactly one pass is made, and there is no pass counter logic.

## Structure
- The shared package bram_stream_reader_pkg holds:
  - the FSM state enum typedef (IDLE, READ, DRAIN, DONE);
  - the FIFO_DEPTH=2 constant.
- Sub-module bram_stream_reader_fifo: a 2-entry synchronous FIFO (RAM_WIDTH+1 bits including last) with push/pop/count and asynchronous reset.

## Test plan
- base=0x010, length=4, BRAM[0x10..0x13]=A0..A3, out_ready=1 -> ram_enable in cycles 1–4 with addresses 0x10..0x13; out_valid in cycles 3–6 with A0..A3; out_last only with A3; done in cycle 7.
- base=0x1FE, length=4 -> addresses 0x1FE, 0x1FF, 0x000, 0x001; data matches BRAM in that order.
- length=8, out_ready toggled by a random 50% pattern -> all 8 words in order with none dropped or duplicated; never more than 2 reads outstanding beyond the last pop.
- length=0 -> done in cycle 1; ram_enable and out_valid stay 0 throughout.
- reset asserted in cycle 4 of a length-16 command -> all outputs go to 0 immediately and no done is produced; a new start after reset streams correctly from its own base.
- BRAM_STREAM_READER_REPEAT_EN defined, repeat=3, length=2 -> stream is B0, B1, B0, B1, B0, B1; out_last only on the 6th word; one done.
